// File: rtl/sync_pkg.sv
// Shared limits and helpers for the debounced synchronizer bank.
package sync_pkg;

  localparam int SYNC_MIN_STAGES   = 2;
  localparam int SYNC_MAX_STAGES   = 4;
  localparam int FILTER_MAX_CYCLES = 255;
  localparam int MAX_CHANNELS      = 64;

  // Counter must hold 0..cycles-1; one extra code keeps the width >= 1 even for cycles=1.
  function automatic int filter_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One channel: SYNC_STAGES flop chain, stability filter and optional edge flops.
// Edge pulses are built only when SYNC_EDGE_DETECT_EN is defined.
module sync_debounce_ch
  import sync_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_async_i,
  output logic d_sync_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                CNT_W    = filter_cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_chain;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_synced;
  logic                   w_commit;

  assign w_synced = r_chain[SYNC_STAGES-1];
  assign w_commit = (w_synced != r_stable) && (r_cnt == CNT_LAST);

  // NOTE: every flop here holds state, so all updates are non-blocking and all
  // of them, including the chain, are forced to the reset level asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_chain  <= {SYNC_STAGES{RESET_VAL}};
      r_stable <= RESET_VAL;
      r_cnt    <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d_async_i};
      if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_stable <= w_synced;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign d_sync_o = r_stable;

`ifdef SYNC_EDGE_DETECT_EN
  logic r_rise;
  logic r_fall;

  // Pulses are registered off the same commit as r_stable so they line up with d_sync_o.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_commit & w_synced;
      r_fall <= w_commit & ~w_synced;
    end
  end

  assign rise_o = r_rise;
  assign fall_o = r_fall;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of NUM_CH independent debounced synchronizers with aggregated change flag.
// Define SYNC_EDGE_DETECT_EN to build the rise/fall/changed pulse logic.
module sync_debounce_bank
  import sync_pkg::*;
#(
  parameter int                NUM_CH        = 8,
  parameter int                SYNC_STAGES   = 2,
  parameter int                FILTER_CYCLES = 4,
  parameter logic [NUM_CH-1:0] RESET_VALUE   = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] d_async_i,
  output logic [NUM_CH-1:0] d_sync_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic              changed_o
);

  if (NUM_CH < 1 || NUM_CH > MAX_CHANNELS) begin : g_bad_num_ch
    $error("sync_debounce_bank: NUM_CH out of range");
  end
  if (SYNC_STAGES < SYNC_MIN_STAGES || SYNC_STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("sync_debounce_bank: SYNC_STAGES out of range");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > FILTER_MAX_CYCLES) begin : g_bad_filter
    $error("sync_debounce_bank: FILTER_CYCLES out of range");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL    (RESET_VALUE[g])
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .d_async_i(d_async_i[g]),
      .d_sync_o (d_sync_o[g]),
      .rise_o   (rise_o[g]),
      .fall_o   (fall_o[g])
    );
  end

  // OR of registered pulses only, so no input reaches this output combinationally.
  assign changed_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Self-checking bench for sync_debounce_bank: directed scenarios plus random toggling
// compared each cycle against a sliding-window reference model.
module tb_sync_debounce_bank;

  localparam int         NCH   = 8;
  localparam int         STG   = 2;
  localparam int         FLT   = 4;
  localparam logic [7:0] RSTV  = 8'hA5;
`ifdef SYNC_EDGE_DETECT_EN
  localparam bit         EDGE_EN = 1'b1;
`else
  localparam bit         EDGE_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [NCH-1:0] d_async_i = '0;
  logic [NCH-1:0] d_sync_o;
  logic [NCH-1:0] rise_o;
  logic [NCH-1:0] fall_o;
  logic           changed_o;

  sync_debounce_bank #(
    .NUM_CH       (NCH),
    .SYNC_STAGES  (STG),
    .FILTER_CYCLES(FLT),
    .RESET_VALUE  (RSTV)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .d_async_i(d_async_i),
    .d_sync_o (d_sync_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .changed_o(changed_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: input delayed by STG edges, output flips once the last FLT
  // synchronized samples all disagree with it.
  logic [NCH-1:0] m_pipe [STG];
  logic [NCH-1:0] m_win  [FLT];
  logic [NCH-1:0] m_out;
  logic [NCH-1:0] m_rise;
  logic [NCH-1:0] m_fall;

  task automatic model_reset();
    for (int k = 0; k < STG; k++) m_pipe[k] = RSTV;
    for (int k = 0; k < FLT; k++) m_win[k] = RSTV;
    m_out  = RSTV;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] flip;
    for (int k = FLT - 1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = m_pipe[STG-1];
    flip = '1;
    for (int k = 0; k < FLT; k++) flip &= (m_win[k] ^ m_out);
    m_out  = m_out ^ flip;
    m_rise = EDGE_EN ? (flip & m_out) : '0;
    m_fall = EDGE_EN ? (flip & ~m_out) : '0;
    for (int k = STG - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = d_async_i;
  endtask

  task automatic compare();
    check("sync", d_sync_o, m_out);
    check("rise", rise_o, m_rise);
    check("fall", fall_o, m_fall);
    check("changed", changed_o, |(m_rise | m_fall));
  endtask

  task automatic step(input logic [NCH-1:0] d);
    @(negedge clk);
    d_async_i = d;
    @(posedge clk);
    model_edge();
    #1 compare();
  endtask

  // Assert reset mid-cycle, hold it for n edges, release between edges.
  task automatic do_reset(input int n);
    @(negedge clk);
    #1 resetn = 1'b0;
    model_reset();
    #1 compare();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 compare();
    end
    #1 resetn = 1'b1;
  endtask

  task automatic measure(input int ch, input logic [NCH-1:0] d, input int exp_n, input string tag);
    int n;
    n = 1;
    step(d);
    while (d_sync_o[ch] !== d[ch] && n < 20) begin
      step(d);
      n++;
    end
    check(tag, n, exp_n);
  endtask

  initial begin
    model_reset();

    // Reset held 10 cycles with inputs low; outputs sit at the reset value.
    do_reset(10);
    check("rst_val", d_sync_o, RSTV);
    step(8'h00);
    check("rel_no_pulse", rise_o | fall_o, 8'h00);
    check("rel_hold", d_sync_o, RSTV);
    for (int i = 0; i < 7; i++) step(8'h00);
    check("settle_low", d_sync_o, 8'h00);

    // Single-channel latency from first capture to output update.
    measure(0, 8'h01, STG + FLT, "lat_ch0");
    for (int i = 0; i < 3; i++) step(8'h01);

    // Three-cycle glitch on ch3 is rejected, a four-cycle pulse passes.
    for (int i = 0; i < 3; i++) step(8'h09);
    for (int i = 0; i < 8; i++) step(8'h01);
    check("glitch3", d_sync_o[3], 1'b0);
    for (int i = 0; i < 4; i++) step(8'h09);
    for (int i = 0; i < 4; i++) step(8'h01);
    check("pulse4_hi", d_sync_o[3], 1'b1);
    for (int i = 0; i < 6; i++) step(8'h01);
    check("pulse4_lo", d_sync_o[3], 1'b0);

    // Every channel toggles on the same cycle.
    measure(0, 8'hFE, STG + FLT, "lat_all");
    check("all_same", d_sync_o, 8'hFE);
    for (int i = 0; i < 3; i++) step(8'hFE);
    measure(0, 8'h01, STG + FLT, "lat_all_back");
    check("all_back", d_sync_o, 8'h01);

    // Reset in the middle of qualifying a ch1 change restarts the count.
    do_reset(3);
    for (int i = 0; i < 8; i++) step(8'h00);
    for (int i = 0; i < 4; i++) step(8'h02);
    do_reset(2);
    check("rst_mid_ch1", d_sync_o[1], RSTV[1]);
    measure(1, 8'h02, STG + FLT, "lat_ch1_rst");

    // Random toggling with occasional glitches and asynchronous resets.
    begin : rand_phase
      logic [NCH-1:0] d;
      logic [NCH-1:0] m;
      d = d_async_i;
      for (int c = 0; c < 2000; c++) begin
        m = '0;
        for (int b = 0; b < NCH; b++) if ($urandom_range(0, 9) == 0) m[b] = 1'b1;
        d = d ^ m;
        step(d);
        if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
